bsg_reduce_serial: RTL and testbench
====================================

// Module: bsg_reduce_serial
// PURPOSE
//  Multi-cycle sequencer for a chunk_p-bit XOR/AND/OR reduction unit.
//  Accepts one width_p-bit operand and a per-transaction op select, then
//  folds one chunk per cycle into a 1-bit accumulator; result returned on v/yumi.
//  Used where a full-width single-cycle reduction tree misses timing or area
//  (wide parity, all-ones and any-set checks in status/ECC logic).
// PARAMETERS
//  width_p  64  operand width; must be >= 1
//  chunk_p  8   bits reduced per cycle; 1 <= chunk_p <= width_p
//  (derived) els_lp = ceil(width_p/chunk_p) = cycles in BUSY; cnt width = max(1,$clog2(els_lp))
// PORTS
//  clk_i      in   1        clock; all state updates on rising edge
//  reset_n_i  in   1        asynchronous, active-low reset
//  v_i        in   1        operand valid
//  data_i     in   width_p  operand
//  op_i       in   2        00=XOR, 01=AND, 10=OR, 11=reserved (executes as XOR)
//  ready_o    out  1        block can accept an operand (state IDLE)
//  v_o        out  1        result valid (state DONE)
//  data_o     out  1        reduction result
//  yumi_i     in   1        consumer takes result; legal only when v_o=1
// BEHAVIOUR
//  - Reset (reset_n_i=0, async assert): state=IDLE, cnt=0, acc=0, op reg=XOR,
//    operand reg=0. Outputs: ready_o=1, v_o=0, data_o=0. Inputs ignored while low.
//    Reset mid-transaction discards the operation; no result is produced.
//  - ready_o = (state==IDLE); v_o = (state==DONE); data_o = acc (any state).
//  - FSM:
//    IDLE: if v_i: latch data_i, op_i; acc<=identity(op); cnt<=0; ->BUSY.
//      identity: XOR/OR=0, AND=1.
//    BUSY: acc <= acc OP reduce(chunk[cnt]); chunk[k]=operand[k*chunk_p +: chunk_p].
//      If cnt==els_lp-1 ->DONE, else cnt<=cnt+1. v_i ignored, no accept.
//    DONE: hold acc; if yumi_i ->IDLE, else stay. v_i ignored, no accept.
//  - Partial last chunk (width_p % chunk_p != 0): missing high bits are padded
//    with identity(op). They never change the result.
//  - Latency: accept at edge E0; v_o=1 from edge E0+els_lp onward.
//    Min issue interval = els_lp+2 cycles (IDLE accept, els_lp BUSY, 1 DONE).
//    DONE->IDLE takes one cycle; there is no same-cycle yumi/accept bypass.
//  - els_lp==1 is legal: one BUSY cycle, then DONE.
//  - Result = ^/&/| of the full latched operand, bit-exact to single-cycle reduction.
//  - Operand and op are captured at accept; later changes to data_i/op_i
//    do not affect an operation in flight.
//  - Assertions (sim only): yumi_i && !v_o is an error; chunk_p out of range
//    is an error; op_i==11 on accept gives a warning.
// TESTING
//  1 w64/c8, XOR, data=64'h1 -> v_o after exactly 8 cycles, data_o=1;
//    data=64'h3 -> data_o=0.
//  2 w64/c8, AND, data=all ones -> 1; data=all ones with bit 63 cleared -> 0
//    (zero in last chunk is caught).
//  3 w64/c8, OR, data=64'h0 -> 0; data=64'h0100_0000_0000_0000 -> 1.
//  4 w10/c4 (els=3, 2 pad bits): AND 10'h3FF -> 1; XOR 10'h200 -> 1;
//    OR 10'h000 -> 0. v_o after 3 cycles each.
//  5 Backpressure: hold yumi_i=0 for 5 cycles in DONE -> v_o, data_o stable,
//    ready_o=0. Pulse v_i with a new operand during BUSY/DONE -> not accepted,
//    result unchanged. After yumi_i, ready_o=1 next cycle.
//  6 Assert reset_n_i=0 mid-BUSY (cycle 3 of 8) -> outputs immediately:
//    ready_o=1, v_o=0, data_o=0. After release, a new XOR 64'h1 completes
//    correctly in 8 cycles. Also op_i=11 with data 64'h7 -> XOR result 1.

Source files
------------

// File: rtl/bsg_reduce_serial.sv
// Serial XOR/AND/OR reduction: folds one chunk_p-bit slice of a latched operand
// per cycle into a 1-bit accumulator, returning the result on a v/yumi handshake.
module bsg_reduce_serial #(
   parameter int width_p = 64,
   parameter int chunk_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   input  logic [1:0]         op_i,
   output logic               ready_o,
   output logic               v_o,
   output logic               data_o,
   input  logic               yumi_i
);

   localparam int els_lp   = (width_p + chunk_p - 1) / chunk_p;
   localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
   localparam int pad_w_lp = els_lp * chunk_p;

   localparam logic [1:0] op_and_lp = 2'b01;
   localparam logic [1:0] op_or_lp  = 2'b10;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e                state_r, state_n;
   logic [pad_w_lp-1:0]   operand_r, operand_n;
   logic [1:0]            op_r, op_n;
   logic                  acc_r, acc_n;
   logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
   logic [pad_w_lp-1:0]   padded_in;
   logic [chunk_p-1:0]    chunk;
   logic                  chunk_red;
   logic                  last_chunk;

   // Pad bits above width_p carry the identity of the requested op, so a
   // partial last chunk reduces exactly like the real bits alone would.
   always_comb begin
      padded_in                = {pad_w_lp{op_i == op_and_lp}};
      padded_in[width_p-1:0]   = data_i;
   end

   always_comb begin
      chunk = '0;
      for (int k = 0; k < els_lp; k++) begin
         if (cnt_r == cnt_w_lp'(k)) chunk = operand_r[k*chunk_p +: chunk_p];
      end
      case (op_r)
         op_and_lp: chunk_red = &chunk;
         op_or_lp:  chunk_red = |chunk;
         default:   chunk_red = ^chunk;
      endcase
   end

   assign last_chunk = (cnt_r == cnt_w_lp'(els_lp - 1));

   always_comb begin
      state_n   = state_r;
      operand_n = operand_r;
      op_n      = op_r;
      acc_n     = acc_r;
      cnt_n     = cnt_r;
      case (state_r)
         IDLE: begin
            if (v_i) begin
               operand_n = padded_in;
               op_n      = op_i;
               acc_n     = (op_i == op_and_lp);
               cnt_n     = '0;
               state_n   = BUSY;
            end
         end
         BUSY: begin
            case (op_r)
               op_and_lp: acc_n = acc_r & chunk_red;
               op_or_lp:  acc_n = acc_r | chunk_red;
               default:   acc_n = acc_r ^ chunk_red;
            endcase
            if (last_chunk) state_n = DONE;
            else            cnt_n   = cnt_r + 1'b1;
         end
         DONE: begin
            if (yumi_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r   <= IDLE;
         operand_r <= '0;
         op_r      <= 2'b00;
         acc_r     <= 1'b0;
         cnt_r     <= '0;
      end else begin
         state_r   <= state_n;
         operand_r <= operand_n;
         op_r      <= op_n;
         acc_r     <= acc_n;
         cnt_r     <= cnt_n;
      end
   end

   assign ready_o = (state_r == IDLE);
   assign v_o     = (state_r == DONE);
   assign data_o  = acc_r;

   chunk_range_a: assert property (@(posedge clk_i) (chunk_p >= 1) && (chunk_p <= width_p))
      else $error("bsg_reduce_serial: chunk_p out of range");

   yumi_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
      else $error("bsg_reduce_serial: yumi_i asserted without v_o");

   op_reserved_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(ready_o && v_i && (op_i == 2'b11)))
      else $warning("bsg_reduce_serial: reserved op 11 accepted, executing as XOR");

endmodule

// File: tb/tb_bsg_reduce_serial.sv
// Bench for bsg_reduce_serial: three configurations (w64/c8, w10/c4, w6/c6)
// driven with directed and random operands, checked against a bit-level model.
module tb_bsg_reduce_serial;

   logic        clk;
   logic        reset_n;
   logic [2:0]  v_in;
   logic [2:0]  yumi_in;
   logic [2:0]  ready_out;
   logic [2:0]  v_out;
   logic [2:0]  res_out;
   logic [63:0] data_in;
   logic [1:0]  op_in;

   int total = 0;
   int bad   = 0;

   int widths  [3] = '{64, 10, 6};
   int els_exp [3] = '{8, 3, 1};

   bsg_reduce_serial #(.width_p(64), .chunk_p(8)) dut_w64 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in[0]), .data_i(data_in[63:0]), .op_i(op_in),
      .ready_o(ready_out[0]), .v_o(v_out[0]), .data_o(res_out[0]), .yumi_i(yumi_in[0]));

   bsg_reduce_serial #(.width_p(10), .chunk_p(4)) dut_w10 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in[1]), .data_i(data_in[9:0]), .op_i(op_in),
      .ready_o(ready_out[1]), .v_o(v_out[1]), .data_o(res_out[1]), .yumi_i(yumi_in[1]));

   bsg_reduce_serial #(.width_p(6), .chunk_p(6)) dut_w6 (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in[2]), .data_i(data_in[5:0]), .op_i(op_in),
      .ready_o(ready_out[2]), .v_o(v_out[2]), .data_o(res_out[2]), .yumi_i(yumi_in[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: reduce the low w bits directly, one bit at a time.
   function automatic logic ref_reduce(input logic [1:0] op, input logic [63:0] data, input int w);
      logic r;
      r = (op == 2'b01);
      for (int i = 0; i < w; i++) begin
         case (op)
            2'b01:   r = r & data[i];
            2'b10:   r = r | data[i];
            default: r = r ^ data[i];
         endcase
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One full transaction: accept, measure latency, hold in DONE with stray
   // valids, then hand the result back with yumi.
   task automatic applyStimulus(input int sel, input logic [1:0] op, input logic [63:0] data,
                                input int hold, input string tag);
      logic exp_res;
      int   cycles;
      exp_res = ref_reduce(op, data, widths[sel]);
      checkOutput({tag, "/ready_idle"}, 64'(ready_out[sel]), 64'd1);
      data_in   = data;
      op_in     = op;
      v_in[sel] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v_in[sel] = 1'b0;
      data_in   = {$urandom, $urandom};
      op_in     = 2'($urandom_range(0, 2));
      cycles    = 0;
      while (!v_out[sel] && cycles < 100) begin
         v_in[sel] = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end
      v_in[sel] = 1'b0;
      checkOutput({tag, "/latency"}, 64'(cycles), 64'(els_exp[sel]));
      checkOutput({tag, "/result"}, 64'(res_out[sel]), 64'(exp_res));
      checkOutput({tag, "/ready_done"}, 64'(ready_out[sel]), 64'd0);
      for (int h = 0; h < hold; h++) begin
         v_in[sel] = 1'($urandom_range(0, 1));
         data_in   = {$urandom, $urandom};
         @(posedge clk);
         @(negedge clk);
         checkOutput({tag, "/hold_v"}, 64'(v_out[sel]), 64'd1);
         checkOutput({tag, "/hold_res"}, 64'(res_out[sel]), 64'(exp_res));
         checkOutput({tag, "/hold_ready"}, 64'(ready_out[sel]), 64'd0);
      end
      v_in[sel] = 1'b0;
      if (v_out[sel]) begin
         yumi_in[sel] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         yumi_in[sel] = 1'b0;
      end
      checkOutput({tag, "/ready_after"}, 64'(ready_out[sel]), 64'd1);
      checkOutput({tag, "/v_after"}, 64'(v_out[sel]), 64'd0);
   endtask

   initial begin
      logic [63:0] rnd;
      int          sel;
      int          mode;
      reset_n = 1'b0;
      v_in    = '0;
      yumi_in = '0;
      data_in = '0;
      op_in   = 2'b00;
      #3;
      for (int s = 0; s < 3; s++) begin
         checkOutput("reset/ready", 64'(ready_out[s]), 64'd1);
         checkOutput("reset/v", 64'(v_out[s]), 64'd0);
         checkOutput("reset/data", 64'(res_out[s]), 64'd0);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      applyStimulus(0, 2'b00, 64'h1, 0, "xor_1");
      applyStimulus(0, 2'b00, 64'h3, 0, "xor_3");
      applyStimulus(0, 2'b01, '1, 0, "and_ones");
      applyStimulus(0, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 0, "and_b63");
      applyStimulus(0, 2'b10, 64'h0, 0, "or_zero");
      applyStimulus(0, 2'b10, 64'h0100_0000_0000_0000, 0, "or_b56");
      applyStimulus(1, 2'b01, 64'h3FF, 0, "w10_and");
      applyStimulus(1, 2'b00, 64'h200, 0, "w10_xor");
      applyStimulus(1, 2'b10, 64'h000, 0, "w10_or");
      applyStimulus(2, 2'b01, 64'h3F, 1, "w6_and");
      applyStimulus(2, 2'b00, 64'h15, 1, "w6_xor");
      applyStimulus(0, 2'b00, 64'h8000_0000_0000_0001, 5, "backpressure");

      data_in = 64'h1;
      op_in   = 2'b00;
      v_in[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v_in[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checkOutput("midbusy/acc", 64'(res_out[0]), 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst/ready", 64'(ready_out[0]), 64'd1);
      checkOutput("midrst/v", 64'(v_out[0]), 64'd0);
      checkOutput("midrst/data", 64'(res_out[0]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, 2'b00, 64'h1, 0, "post_rst_xor");
      applyStimulus(0, 2'b11, 64'h7, 0, "op11_xor");

      for (int n = 0; n < 30; n++) begin
         sel  = $urandom_range(0, 2);
         mode = $urandom_range(0, 3);
         case (mode)
            0:       rnd = {$urandom, $urandom};
            1:       rnd = '1;
            2:       rnd = ~(64'h1 << $urandom_range(0, widths[sel] - 1));
            default: rnd = 64'h1 << $urandom_range(0, widths[sel] - 1);
         endcase
         applyStimulus(sel, 2'($urandom_range(0, 2)), rnd, $urandom_range(0, 3), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
